serial_loader: RTL and testbench



---
 rtl/serial_loader.sv | 240 ++++++++++++++++++++++++
 tb/tb_serial_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_loader.sv
// serial_loader: host byte-protocol program loader and CPU control for the IceBreaker SoC.
// Defining LOADER_DUMP_EN compiles in the 'R' memory-dump command.
module serial_loader #(
  parameter int addr_width   = 9,
  parameter int RESET_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [7:0]            mem_data_in,
  output logic [addr_width-1:0] mem_waddr,
  output logic                  mem_write,
  output logic [addr_width-1:0] mem_raddr,
  input  logic [7:0]            mem_data_out,
  output logic                  mem_sel,
  output logic [addr_width-1:0] start_address,
  output logic                  cpu_reset,
  output logic                  cpu_halt,
  input  logic                  cpu_halted
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [7:0] CH_LOAD    = 8'h4C;
  localparam logic [7:0] CH_EXEC    = 8'h58;
  localparam logic [7:0] CH_HALT    = 8'h48;
  localparam logic [7:0] CH_STAT    = 8'h53;
  localparam logic [7:0] CH_OK      = 8'h4B;
  localparam logic [7:0] CH_UNKNOWN = 8'h3F;

  typedef enum logic [3:0] {
    IDLE, ADDR2, ADDR1, ADDR0, LEN1, LEN0, DATA, RSTHOLD, HALTWAIT, REPLY
`ifdef LOADER_DUMP_EN
    , RD0, RD1, RD2, TXWAIT
`endif
  } state_t;

  typedef enum logic [1:0] {CMD_LOAD, CMD_EXEC, CMD_DUMP} cmd_t;

  state_t                state;
  cmd_t                  cmd;
  logic [addr_width-1:0] addr;
  logic [15:0]           remaining;
  logic [CNT_W-1:0]      rst_cnt;
  logic [7:0]            checksum;
  logic [7:0]            reply;
  logic                  tx_guard;

  logic                  can_tx;
  logic [15:0]           len_next;
  logic [7:0]            sum_next;
  logic [addr_width-1:0] addr_next;
  logic [addr_width-1:0] addr_shift;

  // tx_busy is not trusted in the cycle right after tx_start (tx_guard covers it)
  always_comb begin
    can_tx     = !tx_busy && !tx_start && !tx_guard;
    len_next   = {remaining[15:8], rx_data};
    sum_next   = checksum + rx_data;
    addr_next  = addr + addr_width'(1);
    addr_shift = addr_width'({addr, rx_data});
  end

`ifndef LOADER_DUMP_EN
  logic dump_unused;
  assign dump_unused = ^mem_data_out;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd           <= CMD_LOAD;
      addr          <= '0;
      remaining     <= '0;
      rst_cnt       <= '0;
      checksum      <= '0;
      reply         <= '0;
      tx_guard      <= 1'b0;
      tx_data       <= '0;
      tx_start      <= 1'b0;
      mem_data_in   <= '0;
      mem_waddr     <= '0;
      mem_write     <= 1'b0;
      mem_raddr     <= '0;
      mem_sel       <= 1'b1;
      start_address <= '0;
      cpu_reset     <= 1'b1;
      cpu_halt      <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      mem_write <= 1'b0;
      tx_guard  <= tx_start;
      case (state)
        IDLE: if (rx_valid) begin
          case (rx_data)
            CH_LOAD: begin
              cmd       <= CMD_LOAD;
              mem_sel   <= 1'b1;
              cpu_reset <= 1'b1;
              checksum  <= '0;
              state     <= ADDR2;
            end
            CH_EXEC: begin
              cmd   <= CMD_EXEC;
              state <= ADDR2;
            end
            CH_HALT: begin
              cpu_halt <= 1'b1;
              state    <= HALTWAIT;
            end
            CH_STAT: begin
              reply <= {7'd0, cpu_halted};
              state <= REPLY;
            end
`ifdef LOADER_DUMP_EN
            8'h52: begin
              cmd       <= CMD_DUMP;
              mem_sel   <= 1'b1;
              cpu_reset <= 1'b1;
              state     <= ADDR2;
            end
`endif
            default: begin
              reply <= CH_UNKNOWN;
              state <= REPLY;
            end
          endcase
        end
        ADDR2: if (rx_valid) begin
          addr  <= addr_shift;
          state <= ADDR1;
        end
        ADDR1: if (rx_valid) begin
          addr  <= addr_shift;
          state <= ADDR0;
        end
        ADDR0: if (rx_valid) begin
          addr <= addr_shift;
          if (cmd == CMD_EXEC) begin
            start_address <= addr_shift;
            mem_sel       <= 1'b0;
            cpu_halt      <= 1'b0;
            cpu_reset     <= 1'b1;
            rst_cnt       <= CNT_W'(RESET_CYCLES - 1);
            state         <= RSTHOLD;
          end else begin
            state <= LEN1;
          end
        end
        LEN1: if (rx_valid) begin
          remaining <= {rx_data, 8'h00};
          state     <= LEN0;
        end
        LEN0: if (rx_valid) begin
          remaining <= len_next;
`ifdef LOADER_DUMP_EN
          if (cmd == CMD_DUMP) begin
            if (len_next == '0) begin
              state <= IDLE;
            end else begin
              mem_raddr <= addr;
              state     <= RD0;
            end
          end else
`endif
          if (len_next == '0) begin
            reply <= 8'h00;
            state <= REPLY;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (rx_valid) begin
          mem_waddr   <= addr;
          mem_data_in <= rx_data;
          mem_write   <= 1'b1;
          addr        <= addr_next;
          checksum    <= sum_next;
          remaining   <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            reply <= sum_next;
            state <= REPLY;
          end
        end
        // The 'K' goes out in the same cycle cpu_reset falls when the UART is free
        RSTHOLD: begin
          if (rst_cnt == '0) begin
            cpu_reset <= 1'b0;
            reply     <= CH_OK;
            if (can_tx) begin
              tx_data  <= CH_OK;
              tx_start <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= REPLY;
            end
          end else begin
            rst_cnt <= rst_cnt - CNT_W'(1);
          end
        end
        HALTWAIT: if (cpu_halted) begin
          reply <= CH_OK;
          state <= REPLY;
        end
        REPLY: if (can_tx) begin
          tx_data  <= reply;
          tx_start <= 1'b1;
          state    <= IDLE;
        end
`ifdef LOADER_DUMP_EN
        // mem_raddr is already on the bus in RD0; data is valid while in RD2
        RD0: state <= RD1;
        RD1: state <= RD2;
        RD2: begin
          reply <= mem_data_out;
          state <= TXWAIT;
        end
        TXWAIT: if (can_tx) begin
          tx_data   <= reply;
          tx_start  <= 1'b1;
          addr      <= addr_next;
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            state <= IDLE;
          end else begin
            mem_raddr <= addr_next;
            state     <= RD0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
// Self-checking bench for serial_loader: table vectors, hand-written corner cases and
// randomized loads checked against a protocol-level reference model.
module tb_serial_loader;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy = 1'b0;
  logic [7:0]    mem_data_in;
  logic [AW-1:0] mem_waddr;
  logic          mem_write;
  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_data_out;
  logic          mem_sel;
  logic [AW-1:0] start_address;
  logic          cpu_reset;
  logic          cpu_halt;
  logic          cpu_halted;

  serial_loader #(.addr_width(AW), .RESET_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .mem_data_in(mem_data_in), .mem_waddr(mem_waddr), .mem_write(mem_write),
    .mem_raddr(mem_raddr), .mem_data_out(mem_data_out), .mem_sel(mem_sel),
    .start_address(start_address), .cpu_reset(cpu_reset), .cpu_halt(cpu_halt),
    .cpu_halted(cpu_halted)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  typedef struct {
    string           name;
    int unsigned     n;
    logic [0:9][7:0] b;
    logic [7:0]      reply;
    int unsigned     writes;
    logic [AW-1:0]   first_a;
  } vec_t;

  logic [7:0]  tx_q[$];
  wr_t         wr_q[$];
  logic [7:0]  ram [0:(1<<AW)-1];
  logic [7:0]  rd_p1;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned busy_cnt = 0;
  int unsigned uart_len = 3;
  logic        force_busy = 1'b0;
  logic        hold_pend = 1'b0;
  logic [7:0]  held_byte = '0;
  vec_t        vecs [0:5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous-read RAM with two cycles of latency
  always @(posedge clk) begin
    if (mem_write) ram[mem_waddr] <= mem_data_in;
    rd_p1        <= ram[mem_raddr];
    mem_data_out <= rd_p1;
  end

  // UART transmitter model and write monitor
  always @(negedge clk) begin
    if (hold_pend) begin
      check("tx_data_hold", tx_data, held_byte);
      hold_pend = 1'b0;
    end
    if (tx_start) begin
      check("tx_start_while_busy", tx_busy, 0);
      tx_q.push_back(tx_data);
      held_byte = tx_data;
      hold_pend = 1'b1;
      busy_cnt  = uart_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = force_busy || (busy_cnt > 0);
    if (mem_write) wr_q.push_back({mem_waddr, mem_data_in});
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int unsigned n, input string name);
    int unsigned cyc;
    cyc = 0;
    while (tx_q.size() < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_reply_timeout"}, tx_q.size() >= n, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned hi;
    logic [7:0]  fin [0:3];

    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; cpu_halted = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_cpu_halt", cpu_halt, 0);
    check("rst_mem_sel", mem_sel, 1);
    check("rst_mem_write", mem_write, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_start_address", start_address, 0);
    check("rst_mem_waddr", mem_waddr, 0);
    check("rst_mem_raddr", mem_raddr, 0);
    check("rst_mem_data_in", mem_data_in, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    vecs[0] = '{"load_basic", 9, {8'h4C, 8'h00, 8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'h55, 8'h01, 8'h00},
                8'h00, 3, 9'h010};
    vecs[1] = '{"load_wrap", 8, {8'h4C, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h00, 8'h00},
                8'h33, 2, 9'h1FF};
    vecs[2] = '{"load_len0", 6, {8'h4C, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                8'h00, 0, 9'h000};
    vecs[3] = '{"unknown_ff", 1, {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                8'h3F, 0, 9'h000};
    vecs[4] = '{"status_run", 1, {8'h53, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                8'h00, 0, 9'h000};
`ifdef LOADER_DUMP_EN
    vecs[5] = '{"unknown_00", 1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                8'h3F, 0, 9'h000};
`else
    vecs[5] = '{"dump_absent", 1, {8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                8'h3F, 0, 9'h000};
`endif

    for (int v = 0; v < 6; v++) begin
      tx_q.delete(); wr_q.delete();
      for (int k = 0; k < int'(vecs[v].n); k++) send_byte(vecs[v].b[k], 2);
      wait_tx(1, vecs[v].name);
      repeat (20) @(negedge clk);
      check({vecs[v].name, "_nreply"}, tx_q.size(), 1);
      if (tx_q.size() > 0) check({vecs[v].name, "_reply"}, tx_q[0], vecs[v].reply);
      check({vecs[v].name, "_nwrites"}, wr_q.size(), vecs[v].writes);
      if (wr_q.size() > 0 && vecs[v].writes > 0)
        check({vecs[v].name, "_first_addr"}, wr_q[0].a, vecs[v].first_a);
    end
    check("ram_010", ram[9'h010], 8'hAA);
    check("ram_011", ram[9'h011], 8'h55);
    check("ram_012", ram[9'h012], 8'h01);
    check("ram_1ff", ram[9'h1FF], 8'h11);
    check("ram_000", ram[9'h000], 8'h22);
    check("load_cpu_reset_held", cpu_reset, 1);
    check("load_mem_sel", mem_sel, 1);

`ifdef LOADER_DUMP_EN
    tx_q.delete();
    send_byte(8'h52, 2); send_byte(8'h00, 2); send_byte(8'h00, 2);
    send_byte(8'h10, 2); send_byte(8'h00, 2); send_byte(8'h02, 2);
    wait_tx(2, "dump");
    repeat (20) @(negedge clk);
    check("dump_count", tx_q.size(), 2);
    if (tx_q.size() > 1) begin
      check("dump_byte0", tx_q[0], 8'hAA);
      check("dump_byte1", tx_q[1], 8'h55);
    end
    check("dump_mem_sel", mem_sel, 1);
`endif

    // Execute with idle UART: reply must coincide with cpu_reset falling
    tx_q.delete();
    send_byte(8'h58, 2); send_byte(8'h00, 2); send_byte(8'h00, 2); send_byte(8'h10, 2);
    hi = 0;
    while (cpu_reset && hi < 20) begin hi++; @(negedge clk); end
    check("x_reset_cycles", hi, 2);
    check("x_reply_at_fall", tx_start, 1);
    check("x_reply_byte_at_fall", tx_data, 8'h4B);
    check("x_start_address", start_address, 9'h010);
    check("x_mem_sel", mem_sel, 0);
    check("x_cpu_halt", cpu_halt, 0);
    wait_tx(1, "x");
    if (tx_q.size() > 0) check("x_reply", tx_q[0], 8'h4B);

    // Execute while the UART is busy: reply deferred until tx_busy drops
    repeat (10) @(negedge clk);
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    tx_q.delete();
    send_byte(8'h58, 2); send_byte(8'h00, 2); send_byte(8'h00, 2); send_byte(8'h20, 2);
    hi = 0;
    while (cpu_reset && hi < 20) begin hi++; @(negedge clk); end
    check("xb_reset_cycles", hi, 2);
    check("xb_no_start_busy", tx_start, 0);
    repeat (10) @(negedge clk);
    check("xb_held", tx_q.size(), 0);
    force_busy = 1'b0;
    wait_tx(1, "xb");
    if (tx_q.size() > 0) check("xb_reply", tx_q[0], 8'h4B);
    check("xb_start_address", start_address, 9'h020);

    // Halt with delayed cpu_halted
    repeat (10) @(negedge clk);
    tx_q.delete();
    send_byte(8'h48, 2);
    repeat (50) @(negedge clk);
    check("h_cpu_halt", cpu_halt, 1);
    check("h_no_early_reply", tx_q.size(), 0);
    cpu_halted = 1'b1;
    wait_tx(1, "h");
    if (tx_q.size() > 0) check("h_reply", tx_q[0], 8'h4B);
    repeat (10) @(negedge clk);
    tx_q.delete();
    send_byte(8'h53, 2);
    wait_tx(1, "s_halted");
    if (tx_q.size() > 0) check("s_halted_reply", tx_q[0], 8'h01);

    // Unknown byte while tx_busy is held high for 100 cycles
    repeat (10) @(negedge clk);
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    tx_q.delete(); wr_q.delete();
    send_byte(8'h7A, 2);
    repeat (100) @(negedge clk);
    check("busy_held_no_tx", tx_q.size(), 0);
    force_busy = 1'b0;
    wait_tx(1, "unknown_7a");
    if (tx_q.size() > 0) check("unknown_7a_reply", tx_q[0], 8'h3F);
    check("unknown_7a_nwrites", wr_q.size(), 0);

    // Reset in the middle of a load aborts it silently
    repeat (10) @(negedge clk);
    cpu_halted = 1'b0;
    tx_q.delete();
    send_byte(8'h4C, 2); send_byte(8'h00, 2); send_byte(8'h00, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_cpu_reset", cpu_reset, 1);
    check("mid_rst_cpu_halt", cpu_halt, 0);
    check("mid_rst_start_address", start_address, 0);
    repeat (20) @(negedge clk);
    check("mid_rst_no_reply", tx_q.size(), 0);
    send_byte(8'h53, 2);
    wait_tx(1, "mid_rst_status");
    if (tx_q.size() > 0) check("mid_rst_status_reply", tx_q[0], 8'h00);
    repeat (20) @(negedge clk);

    // Randomized commands against the protocol-level model
    for (int it = 0; it < 30; it++) begin
      int unsigned kind, len, sum, base;
      logic [23:0] a24;
      logic [7:0]  b;
      logic [7:0]  dq[$];
      kind = $urandom_range(0, 9);
      uart_len = $urandom_range(1, 12);
      tx_q.delete(); wr_q.delete(); dq.delete();
      if (kind < 6) begin
        a24 = 24'($urandom);
        len = $urandom_range(0, 6);
        for (int k = 0; k < int'(len); k++) dq.push_back(8'($urandom));
        send_byte(8'h4C, $urandom_range(1, 4));
        send_byte(a24[23:16], $urandom_range(1, 4));
        send_byte(a24[15:8], $urandom_range(1, 4));
        send_byte(a24[7:0], $urandom_range(1, 4));
        send_byte(8'(len >> 8), $urandom_range(1, 4));
        send_byte(8'(len), $urandom_range(1, 4));
        foreach (dq[k]) send_byte(dq[k], $urandom_range(1, 4));
        wait_tx(1, "rnd_load");
        repeat (20) @(negedge clk);
        base = a24 % (1 << AW);
        sum = 0;
        foreach (dq[k]) sum = (sum + dq[k]) % 256;
        if (tx_q.size() > 0) check("rnd_load_reply", tx_q[0], sum);
        check("rnd_load_nwrites", wr_q.size(), len);
        for (int k = 0; k < int'(len) && k < wr_q.size(); k++) begin
          check("rnd_load_waddr", wr_q[k].a, (base + k) % (1 << AW));
          check("rnd_load_wdata", wr_q[k].d, dq[k]);
        end
      end else if (kind < 8) begin
        cpu_halted = 1'($urandom_range(0, 1));
        send_byte(8'h53, $urandom_range(2, 4));
        wait_tx(1, "rnd_status");
        repeat (15) @(negedge clk);
        if (tx_q.size() > 0) check("rnd_status_reply", tx_q[0], cpu_halted ? 1 : 0);
      end else begin
        b = 8'($urandom);
        while (b == 8'h4C || b == 8'h58 || b == 8'h48 || b == 8'h53 || b == 8'h52) b = 8'($urandom);
        send_byte(b, $urandom_range(1, 4));
        wait_tx(1, "rnd_unknown");
        repeat (15) @(negedge clk);
        if (tx_q.size() > 0) check("rnd_unknown_reply", tx_q[0], 8'h3F);
        check("rnd_unknown_nwrites", wr_q.size(), 0);
      end
    end

`ifdef LOADER_DUMP_EN
    // Dump across the address wrap
    for (int k = 0; k < 4; k++) fin[k] = 8'($urandom);
    tx_q.delete();
    send_byte(8'h4C, 2); send_byte(8'h00, 2); send_byte(8'h01, 2); send_byte(8'hFE, 2);
    send_byte(8'h00, 2); send_byte(8'h04, 2);
    for (int k = 0; k < 4; k++) send_byte(fin[k], 2);
    wait_tx(1, "wrap_load");
    repeat (20) @(negedge clk);
    if (tx_q.size() > 0) check("wrap_load_reply", tx_q[0], 8'(fin[0] + fin[1] + fin[2] + fin[3]));
    tx_q.delete();
    send_byte(8'h52, 2); send_byte(8'h00, 2); send_byte(8'h01, 2); send_byte(8'hFE, 2);
    send_byte(8'h00, 2); send_byte(8'h04, 2);
    wait_tx(4, "wrap_dump");
    repeat (20) @(negedge clk);
    check("wrap_dump_count", tx_q.size(), 4);
    for (int k = 0; k < 4 && k < tx_q.size(); k++) check("wrap_dump_byte", tx_q[k], fin[k]);
`else
    fin[0] = 8'h00;
    fin[1] = fin[0];
    fin[2] = fin[1];
    fin[3] = fin[2];
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
